// File: rtl/ser_feed.sv
// rtl/ser_feed.sv - buffered parallel-to-serial feeder (optional frame parity via SER_FEED_PARITY_EN)
module ser_feed #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         datain,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dataout,
  output logic                     dout_vld,
  output logic                     ovf
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
`ifdef SER_FEED_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int SR_W = WIDTH + PAR_W;
  localparam int BCW  = $clog2(SR_W + 1);
  localparam logic [BCW-1:0]  LAST_BIT = BCW'(SR_W - 1);
  localparam logic [AW-1:0]   PTR_MAX  = AW'(DEPTH - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic [SR_W-1:0]   shift_q, shift_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              push;
  logic              pop;
  logic [WIDTH-1:0]  head;
  logic [SR_W-1:0]   load_word;

  // Writes are accepted only against the registered full flag, so a same-edge pop never rescues a write.
  assign push = wr_en & ~full_q;
  assign head = mem[rd_ptr_q];

`ifdef SER_FEED_PARITY_EN
  assign load_word = {head, ^head};
`else
  assign load_word = head;
`endif

  // Buffer storage; contents are only meaningful once written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= datain;
    end
  end

  // State register for FSM, shifter, pointers and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Next-state logic: pop decision uses registered empty, so a word written into an empty buffer waits one edge.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop       = 1'b1;
          shift_d   = load_word;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          if (!empty_q) begin
            pop       = 1'b1;
            shift_d   = load_word;
            bit_cnt_d = '0;
          end else begin
            shift_d   = '0;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end
        end else begin
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        shift_d   = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  // FIFO bookkeeping: pointers wrap at DEPTH-1, flags follow the post-edge occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNTW'(push) - CNTW'(pop);
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
    ovf_d   = ovf_q | (wr_en & full_q);
  end

  // Output logic: serial line is driven only while a frame is in flight.
  always_comb begin
    dataout  = 1'b0;
    dout_vld = 1'b0;
    if (state_q == SHIFT) begin
      dataout  = shift_q[SR_W-1];
      dout_vld = 1'b1;
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_ser_feed.sv
// tb/tb_ser_feed.sv - directed self-checking bench for ser_feed
module tb_ser_feed;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef SER_FEED_PARITY_EN
  localparam int FR = WIDTH + 1;
`else
  localparam int FR = WIDTH;
`endif

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] datain;
  logic             wr_en;
  logic             full;
  logic             empty;
  logic [2:0]       count;
  logic             dataout;
  logic             dout_vld;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  logic       bits [$];
  int         n_vld, first_cyc, last_cyc, max_cnt, cyc;
  int         epoch = 0;
  int         seen_epoch = 0;
  logic [7:0] exp_q [$];

  ser_feed #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .datain(datain), .wr_en(wr_en),
    .full(full), .empty(empty), .count(count),
    .dataout(dataout), .dout_vld(dout_vld), .ovf(ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output monitor on the falling edge; statistics restart whenever epoch moves.
  initial begin
    n_vld = 0; first_cyc = -1; last_cyc = -1; max_cnt = 0; cyc = 0;
    forever begin
      @(negedge clk);
      if (epoch != seen_epoch) begin
        bits.delete();
        n_vld = 0; first_cyc = -1; last_cyc = -1; max_cnt = 0;
        seen_epoch = epoch;
      end
      cyc++;
      if (rst_n) begin
        if (dout_vld) begin
          bits.push_back(dataout);
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          n_vld++;
        end
        if (int'(count) > max_cnt) max_cnt = int'(count);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    wr_en  = 1'b0;
    datain = '0;
    step();
    step();
    rst_n = 1'b1;
    epoch++;
    exp_q.delete();
  endtask

  task automatic write_word(input logic [7:0] w);
    datain = w;
    wr_en  = 1'b1;
    exp_q.push_back(w);
    step();
    wr_en  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_frames(input string tag, input int n);
    logic [7:0] w;
    logic       b;
    chk({tag, "_nvld"}, n_vld, n * FR);
    chk({tag, "_gapless"}, last_cyc - first_cyc + 1, n_vld);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < WIDTH; j++) begin
        b = (k * FR + j < bits.size()) ? bits[k * FR + j] : 1'bx;
        w = {w[6:0], b};
      end
      chk($sformatf("%s_word%0d", tag, k), w, exp_q[k]);
`ifdef SER_FEED_PARITY_EN
      b = (k * FR + WIDTH < bits.size()) ? bits[k * FR + WIDTH] : 1'bx;
      chk($sformatf("%s_par%0d", tag, k), b, ^exp_q[k]);
`endif
    end
  endtask

  initial begin
    logic [7:0] a5;
    int         waited;
    rst_n = 1'b1; wr_en = 1'b0; datain = '0;
    #2;

    // Reset values
    do_reset();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_vld", dout_vld, 0);
    chk("rst_dout", dataout, 0);
    chk("rst_ovf", ovf, 0);

    // Single word latency and bit order
    a5 = 8'hA5;
    write_word(a5);
    chk("sw_cnt_after_wr", count, 1);
    chk("sw_empty_after_wr", empty, 0);
    chk("sw_vld_after_wr", dout_vld, 0);
    step();
    chk("sw_cnt_after_pop", count, 0);
    chk("sw_empty_after_pop", empty, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("sw_bit%0d", i), dataout, a5[7-i]);
      chk($sformatf("sw_vld%0d", i), dout_vld, 1);
      step();
    end
`ifdef SER_FEED_PARITY_EN
    chk("sw_par", dataout, ^a5);
    chk("sw_par_vld", dout_vld, 1);
    step();
`endif
    chk("sw_idle_vld", dout_vld, 0);
    chk("sw_idle_dout", dataout, 0);

    // Back-to-back frames with no gap
    do_reset();
    write_word(8'hFF);
    write_word(8'h00);
    write_word(8'h81);
    idle(40);
    check_frames("b2b", 3);

    // Overflow: sixth write dropped while full
    do_reset();
    for (int i = 0; i < 6; i++) begin
      datain = 8'h10 + 8'(i);
      wr_en  = 1'b1;
      if (i < 5) exp_q.push_back(datain);
      step();
      if (i == 4) begin
        chk("ovf_full_at5", full, 1);
        chk("ovf_clear_at5", ovf, 0);
      end
    end
    wr_en = 1'b0;
    chk("ovf_full", full, 1);
    chk("ovf_cnt", count, 4);
    chk("ovf_set", ovf, 1);
    idle(60);
    check_frames("ovf", 5);
    chk("ovf_sticky", ovf, 1);
    chk("ovf_drained", empty, 1);

    // Parity-sensitive payloads
    do_reset();
    write_word(8'h07);
    write_word(8'h03);
    idle(30);
    check_frames("par", 2);
`ifdef SER_FEED_PARITY_EN
    chk("par_07_tail", bits[8], 1);
    chk("par_03_tail", bits[17], 0);
`endif

    // Reset mid-frame
    do_reset();
    write_word(8'hC3);
    write_word(8'h11);
    write_word(8'h22);
    idle(2);
    chk("mid_bit3", dataout, 0);
    chk("mid_vld", dout_vld, 1);
    chk("mid_cnt", count, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", dataout, 0);
    chk("mid_rst_vld", dout_vld, 0);
    chk("mid_rst_cnt", count, 0);
    chk("mid_rst_empty", empty, 1);
    step();
    rst_n = 1'b1;
    epoch++;
    idle(20);
    chk("mid_no_out", n_vld, 0);
    chk("mid_still_empty", empty, 1);

    // Pointer wrap with random gaps
    do_reset();
    for (int i = 0; i < 10; i++) begin
      idle($urandom_range(0, 3));
      waited = 0;
      while (full && waited < 50) begin
        step();
        waited++;
      end
      if (waited >= 50) chk("wrap_full_timeout", full, 0);
      write_word(8'($urandom));
    end
    idle(100);
    check_frames("wrap", 10);
    chk("wrap_maxcnt_le4", (max_cnt <= 4) ? 1 : 0, 1);
    chk("wrap_no_ovf", ovf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
